// File: rtl/regfile_dump.sv
// 2-read/1-write register file with registered reads, write-to-read bypass and optional zero register.
// A valid/ready dump engine streams every register, in index order, to the debug/trace unit.
module regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_dump_start,
  output logic              o_dump_busy,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_idx,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [ADDR_W-1:0] r_dump_idx;
  logic [ADDR_W-1:0] w_dump_idx_nxt;
  logic [DATA_W-1:0] w_rd1_nxt;
  logic [DATA_W-1:0] w_rd2_nxt;
  logic              w_wr_en;

  assign w_wr_en = i_we && !(ZERO_REG && (i_wa == '0));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Bypass lets a read in the same cycle as the write see the new value.
  always_comb begin
    w_rd1_nxt = r_regs[i_ra1];
    if (w_wr_en && (i_wa == i_ra1)) w_rd1_nxt = i_wd;
    if (ZERO_REG && (i_ra1 == '0))  w_rd1_nxt = '0;
  end

  always_comb begin
    w_rd2_nxt = r_regs[i_ra2];
    if (w_wr_en && (i_wa == i_ra2)) w_rd2_nxt = i_wd;
    if (ZERO_REG && (i_ra2 == '0))  w_rd2_nxt = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd1 <= '0;
      o_rd2 <= '0;
    end else begin
      o_rd1 <= w_rd1_nxt;
      o_rd2 <= w_rd2_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_dump_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dump_idx <= w_dump_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dump_idx_nxt = r_dump_idx;
    case (r_state)
      IDLE: begin
        if (i_dump_start) begin
          w_state_nxt    = SCAN;
          w_dump_idx_nxt = '0;
        end
      end
      SCAN: begin
        if (i_dump_ready) begin
          if (r_dump_idx == LAST_IDX) w_state_nxt = DONE;
          else                        w_dump_idx_nxt = r_dump_idx + ADDR_W'(1);
        end
      end
      DONE: begin
        w_state_nxt    = IDLE;
        w_dump_idx_nxt = '0;
      end
      default: begin
        w_state_nxt    = IDLE;
        w_dump_idx_nxt = '0;
      end
    endcase
  end

  always_comb begin
    o_dump_valid = (r_state == SCAN);
    o_dump_done  = (r_state == DONE);
    o_dump_busy  = (r_state != IDLE);
  end

  // Dump data reads the live array, so a stalled beat follows later writes.
  assign o_dump_idx  = r_dump_idx;
  assign o_dump_data = (ZERO_REG && (r_dump_idx == '0)) ? '0 : r_regs[r_dump_idx];

endmodule
